ttt_game_ctrl: RTL and testbench

Game controller upstream of the tic-tac-toe VGA renderer: decodes the debounced rotary encoder into the cursor `square_num` that the renderer highlights. It places alternating player markers on rotary push and holds the 3x3 board state. It also detects win and draw, and publishes board, turn and result flags for the renderer and status LEDs.

---
 rtl/ttt_game_ctrl.sv | 170 +++++++++++++++++
 tb/tb_ttt_game_ctrl.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ttt_game_ctrl.sv
// ---------------------------------------------------------------------------
// ttt_game_ctrl
//
// Tic-tac-toe game controller sitting in front of the VGA renderer. The
// debounced rotary encoder moves a cursor over the 3x3 board. A push on the
// encoder places the current player's marker. The block keeps the board,
// detects wins and draws, and publishes everything as registered outputs.
//
// Ports:
//   clk          in   1   system clock
//   clr          in   1   synchronous active-high reset
//   rot_a        in   1   debounced rotary channel A
//   rot_b        in   1   debounced rotary channel B (direction)
//   rot_ctr      in   1   debounced rotary push button, level, high = pressed
//   square_num   out  8   cursor square 1..9 row-major, 0 once the game is over
//   board        out 18   square k at bits [2k-1:2k-2]: 00 empty, 01 P1, 10 P2
//   turn         out  1   player to move: 0 = player 1, 1 = player 2
//   move_count   out  4   markers placed, 0..9
//   player_1_win out  1   held until new game or reset
//   player_2_win out  1   held until new game or reset
//   draw         out  1   board full with no winner
// ---------------------------------------------------------------------------
module ttt_game_ctrl (
    input  logic        clk,
    input  logic        clr,
    input  logic        rot_a,
    input  logic        rot_b,
    input  logic        rot_ctr,
    output logic [7:0]  square_num,
    output logic [17:0] board,
    output logic        turn,
    output logic [3:0]  move_count,
    output logic        player_1_win,
    output logic        player_2_win,
    output logic        draw
);

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        CHECK = 2'd1,
        WIN   = 2'd2,
        DRAW  = 2'd3
    } state_t;

    state_t      state_q;

    // Input synchronizers. B is only looked at on the A rising edge, which
    // is detected between a_q1 and a_q2, so b_q1 is the stage that lines up.
    logic        a_q1, a_q2;
    logic        b_q1;
    logic        ctr_q1, ctr_q2;

    logic [3:0]  cursor_q;
    logic [17:0] board_q;
    logic        turn_q;
    logic [3:0]  move_count_q;
    logic        p1_win_q, p2_win_q, draw_q;

    logic        step;
    logic        press;
    logic [4:0]  sq_idx;
    logic [1:0]  cur_sq;
    logic [1:0]  mover_code;

    // True when every square of any of the 8 lines holds code c.
    function automatic logic line_won(input logic [17:0] b, input logic [1:0] c);
        logic [8:0] m;
        for (int k = 0; k < 9; k++) begin
            m[k] = (b[2*k +: 2] == c);
        end
        return (m[0] & m[1] & m[2]) | (m[3] & m[4] & m[5]) | (m[6] & m[7] & m[8]) |
               (m[0] & m[3] & m[6]) | (m[1] & m[4] & m[7]) | (m[2] & m[5] & m[8]) |
               (m[0] & m[4] & m[8]) | (m[2] & m[4] & m[6]);
    endfunction

    assign step       = a_q1 & ~a_q2;
    assign press      = ctr_q1 & ~ctr_q2;
    // Bit offset of the cursor square; only meaningful while cursor is 1..9.
    assign sq_idx     = {cursor_q - 4'd1, 1'b0};
    assign cur_sq     = board_q[sq_idx +: 2];
    assign mover_code = turn_q ? 2'b10 : 2'b01;

    always_ff @(posedge clk) begin
        if (clr) begin
            a_q1         <= 1'b0;
            a_q2         <= 1'b0;
            b_q1         <= 1'b0;
            ctr_q1       <= 1'b0;
            ctr_q2       <= 1'b0;
            state_q      <= PLAY;
            cursor_q     <= 4'd1;
            board_q      <= '0;
            turn_q       <= 1'b0;
            move_count_q <= 4'd0;
            p1_win_q     <= 1'b0;
            p2_win_q     <= 1'b0;
            draw_q       <= 1'b0;
        end else begin
            a_q1   <= rot_a;
            a_q2   <= a_q1;
            b_q1   <= rot_b;
            ctr_q1 <= rot_ctr;
            ctr_q2 <= ctr_q1;

            case (state_q)
                PLAY: begin
                    // A press takes priority; a coincident step is dropped.
                    if (press) begin
                        if (cur_sq == 2'b00) begin
                            board_q[sq_idx +: 2] <= mover_code;
                            move_count_q         <= move_count_q + 4'd1;
                            state_q              <= CHECK;
                        end
                    end else if (step) begin
                        if (!b_q1) begin
                            cursor_q <= (cursor_q == 4'd9) ? 4'd1 : cursor_q + 4'd1;
                        end else begin
                            cursor_q <= (cursor_q == 4'd1) ? 4'd9 : cursor_q - 4'd1;
                        end
                    end
                end

                // board_q already holds the new marker here. Win is tested
                // before the full-board test so a winning ninth move wins.
                CHECK: begin
                    if (line_won(board_q, mover_code)) begin
                        if (turn_q) begin
                            p2_win_q <= 1'b1;
                        end else begin
                            p1_win_q <= 1'b1;
                        end
                        cursor_q <= 4'd0;
                        state_q  <= WIN;
                    end else if (move_count_q == 4'd9) begin
                        draw_q   <= 1'b1;
                        cursor_q <= 4'd0;
                        state_q  <= DRAW;
                    end else begin
                        turn_q  <= ~turn_q;
                        state_q <= PLAY;
                    end
                end

                WIN, DRAW: begin
                    if (press) begin
                        board_q      <= '0;
                        move_count_q <= 4'd0;
                        turn_q       <= 1'b0;
                        p1_win_q     <= 1'b0;
                        p2_win_q     <= 1'b0;
                        draw_q       <= 1'b0;
                        cursor_q     <= 4'd1;
                        state_q      <= PLAY;
                    end
                end

                default: state_q <= PLAY;
            endcase
        end
    end

    assign square_num   = {4'd0, cursor_q};
    assign board        = board_q;
    assign turn         = turn_q;
    assign move_count   = move_count_q;
    assign player_1_win = p1_win_q;
    assign player_2_win = p2_win_q;
    assign draw         = draw_q;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
module tb_ttt_game_ctrl;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        rot_a = 1'b0;
    logic        rot_b = 1'b0;
    logic        rot_ctr = 1'b0;
    logic [7:0]  square_num;
    logic [17:0] board;
    logic        turn;
    logic [3:0]  move_count;
    logic        player_1_win;
    logic        player_2_win;
    logic        draw;

    ttt_game_ctrl dut (
        .clk          (clk),
        .clr          (clr),
        .rot_a        (rot_a),
        .rot_b        (rot_b),
        .rot_ctr      (rot_ctr),
        .square_num   (square_num),
        .board        (board),
        .turn         (turn),
        .move_count   (move_count),
        .player_1_win (player_1_win),
        .player_2_win (player_2_win),
        .draw         (draw)
    );

    always #5 clk = ~clk;

    logic [33:0] obs_vec;
    assign obs_vec = {square_num, board, turn, move_count, player_1_win, player_2_win, draw};

    typedef struct {
        string       name;
        logic [33:0] exp;
    } sb_t;
    sb_t sb[$];

    int n_cmp = 0;
    int n_err = 0;

    // Reference model of the game.
    logic [1:0] mb [1:9];
    logic [3:0] mcur;
    logic       mturn;
    logic [3:0] mmc;
    logic       mp1, mp2, mdraw;

    int lines [8][3] = '{'{1,2,3}, '{4,5,6}, '{7,8,9}, '{1,4,7},
                         '{2,5,8}, '{3,6,9}, '{1,5,9}, '{3,5,7}};

    function automatic void model_reset();
        for (int k = 1; k <= 9; k++) mb[k] = 2'd0;
        mcur  = 4'd1;
        mturn = 1'b0;
        mmc   = 4'd0;
        mp1   = 1'b0;
        mp2   = 1'b0;
        mdraw = 1'b0;
    endfunction

    function automatic logic [33:0] exp_vec();
        logic [17:0] b;
        b = '0;
        for (int k = 1; k <= 9; k++) b[2*k-2 +: 2] = mb[k];
        return {4'd0, mcur, b, mturn, mmc, mp1, mp2, mdraw};
    endfunction

    function automatic void model_step(input logic dir);
        if (mp1 || mp2 || mdraw) return;
        if (!dir) mcur = (mcur == 4'd9) ? 4'd1 : mcur + 4'd1;
        else      mcur = (mcur == 4'd1) ? 4'd9 : mcur - 4'd1;
    endfunction

    // Returns 1 when a marker was actually placed.
    function automatic bit model_place();
        if (mp1 || mp2 || mdraw) begin
            model_reset();
            return 1'b0;
        end
        if (mb[mcur] != 2'd0) return 1'b0;
        mb[mcur] = mturn ? 2'd2 : 2'd1;
        mmc = mmc + 4'd1;
        return 1'b1;
    endfunction

    function automatic void model_check();
        logic [1:0] code;
        bit won;
        code = mturn ? 2'd2 : 2'd1;
        won = 1'b0;
        for (int l = 0; l < 8; l++)
            if (mb[lines[l][0]] == code && mb[lines[l][1]] == code && mb[lines[l][2]] == code)
                won = 1'b1;
        if (won) begin
            if (mturn) mp2 = 1'b1; else mp1 = 1'b1;
            mcur = 4'd0;
        end else if (mmc == 4'd9) begin
            mdraw = 1'b1;
            mcur  = 4'd0;
        end else begin
            mturn = ~mturn;
        end
    endfunction

    function automatic void model_press();
        if (model_place()) model_check();
    endfunction

    // Stimulus drivers: start just after a rising edge, end #1 after the
    // edge at which the DUT result is fully settled.
    task automatic do_reset();
        clr = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 clr = 1'b0;
        model_reset();
    endtask

    task automatic drv_step(input logic dir);
        rot_b = dir;
        rot_a = 1'b1;
        @(posedge clk);
        #1 rot_a = 1'b0;
        rot_b = 1'b0;
        @(posedge clk);
        #1;
        model_step(dir);
    endtask

    task automatic drv_press();
        rot_ctr = 1'b1;
        @(posedge clk);
        #1 rot_ctr = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        model_press();
    endtask

    task automatic drv_goto(input int k);
        for (int i = 0; i < 9 && mcur != 4'(k); i++) drv_step(1'b0);
    endtask

    task automatic test_reset();
        sb_t e;
        rot_a = 1'b0; rot_b = 1'b0; rot_ctr = 1'b0;
        do_reset();
        sb.push_back('{"reset", exp_vec()});
        e = sb.pop_front();
        n_cmp++;
        if (obs_vec !== e.exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", e.name, obs_vec, e.exp);
        end
    endtask

    task automatic test_rotation();
        sb_t e;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drv_step(1'b0);
            sb.push_back('{$sformatf("rot_cw_%0d", i), exp_vec()});
            e = sb.pop_front();
            n_cmp++;
            if (obs_vec !== e.exp) begin
                n_err++;
                $display("FAIL %s: got %h expected %h", e.name, obs_vec, e.exp);
            end
        end
        // From 2: CCW to 1, then CCW wraps to 9.
        for (int i = 0; i < 2; i++) begin
            drv_step(1'b1);
            sb.push_back('{$sformatf("rot_ccw_%0d", i), exp_vec()});
            e = sb.pop_front();
            n_cmp++;
            if (obs_vec !== e.exp) begin
                n_err++;
                $display("FAIL %s: got %h expected %h", e.name, obs_vec, e.exp);
            end
        end
    endtask

    task automatic test_place();
        sb_t e;
        bit  placed;
        do_reset();
        drv_goto(5);
        rot_ctr = 1'b1;
        @(posedge clk);
        #1 rot_ctr = 1'b0;
        placed = model_place();
        sb.push_back('{"place_e1", exp_vec()});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        n_cmp++;
        if (obs_vec !== e.exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", e.name, obs_vec, e.exp);
        end
        if (placed) model_check();
        sb.push_back('{"place_e2", exp_vec()});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        n_cmp++;
        if (obs_vec !== e.exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", e.name, obs_vec, e.exp);
        end
        drv_press();
        sb.push_back('{"place_occupied", exp_vec()});
        e = sb.pop_front();
        n_cmp++;
        if (obs_vec !== e.exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", e.name, obs_vec, e.exp);
        end
    endtask

    task automatic play_seq(input string tag, input int seq[$]);
        sb_t e;
        foreach (seq[i]) begin
            drv_goto(seq[i]);
            drv_press();
            sb.push_back('{$sformatf("%s_mv%0d", tag, i + 1), exp_vec()});
            e = sb.pop_front();
            n_cmp++;
            if (obs_vec !== e.exp) begin
                n_err++;
                $display("FAIL %s: got %h expected %h", e.name, obs_vec, e.exp);
            end
        end
    endtask

    task automatic test_p1_win();
        sb_t e;
        do_reset();
        play_seq("p1win", '{1, 4, 2, 5, 3});
        drv_step(1'b0);
        sb.push_back('{"p1win_rot_ignored", exp_vec()});
        e = sb.pop_front();
        n_cmp++;
        if (obs_vec !== e.exp || player_1_win !== 1'b1) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", e.name, obs_vec, e.exp);
        end
        drv_press();
        sb.push_back('{"p1win_new_game", exp_vec()});
        e = sb.pop_front();
        n_cmp++;
        if (obs_vec !== e.exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", e.name, obs_vec, e.exp);
        end
    endtask

    task automatic test_draw();
        sb_t e;
        do_reset();
        play_seq("draw", '{1, 2, 3, 5, 4, 6, 8, 7, 9});
        n_cmp++;
        if (draw !== 1'b1 || move_count !== 4'd9) begin
            n_err++;
            $display("FAIL draw_flag: got draw=%b count=%0d expected draw=1 count=9", draw, move_count);
        end
        drv_press();
        sb.push_back('{"draw_new_game", exp_vec()});
        e = sb.pop_front();
        n_cmp++;
        if (obs_vec !== e.exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", e.name, obs_vec, e.exp);
        end
    endtask

    task automatic test_win_on_nine();
        do_reset();
        play_seq("win9", '{1, 3, 2, 4, 5, 7, 6, 8, 9});
        n_cmp++;
        if (player_1_win !== 1'b1 || draw !== 1'b0 || move_count !== 4'd9) begin
            n_err++;
            $display("FAIL win9_flags: got p1=%b draw=%b count=%0d expected p1=1 draw=0 count=9",
                     player_1_win, draw, move_count);
        end
    endtask

    task automatic test_press_step_same();
        sb_t e;
        do_reset();
        rot_a   = 1'b1;
        rot_ctr = 1'b1;
        @(posedge clk);
        #1 rot_a = 1'b0;
        rot_ctr = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        model_press();
        sb.push_back('{"press_and_step", exp_vec()});
        e = sb.pop_front();
        n_cmp++;
        if (obs_vec !== e.exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", e.name, obs_vec, e.exp);
        end
    endtask

    task automatic test_clr_in_check();
        sb_t e;
        do_reset();
        play_seq("clr", '{1, 4, 2, 5});
        drv_goto(3);
        rot_ctr = 1'b1;
        @(posedge clk);
        #1 rot_ctr = 1'b0;
        @(posedge clk);
        // DUT is in CHECK now with the winning marker placed.
        #1 clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        model_reset();
        sb.push_back('{"clr_check_next", exp_vec()});
        e = sb.pop_front();
        n_cmp++;
        if (obs_vec !== e.exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", e.name, obs_vec, e.exp);
        end
        repeat (3) @(posedge clk);
        #1;
        sb.push_back('{"clr_check_later", exp_vec()});
        e = sb.pop_front();
        n_cmp++;
        if (obs_vec !== e.exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", e.name, obs_vec, e.exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_rotation();
        test_place();
        test_p1_win();
        test_draw();
        test_win_on_nine();
        test_press_step_same();
        test_clr_in_check();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
